// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction prefetcher: reserves a FIFO slot per word read, buffers {instr, pc}, flushes on redirect.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module fetch_prefetch_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = `RISCV_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         fetch_valid_o,
  output logic [ADDR_WIDTH-1:0]        fetch_addr_o,
  input  logic                         fetch_ready_i,
  input  logic [`RISCV_WORD_WIDTH-1:0] fetch_rdata_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [`RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]        instr_pc_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                  perf_fetch_cnt_o,
  output logic [31:0]                  perf_stall_cnt_o,
`endif
  input  logic                         redirect_i,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc_i
);

  localparam int unsigned WW = `RISCV_WORD_WIDTH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic                  r_fetch_valid;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_out;
  logic                  r_stale;
  logic [ADDR_WIDTH-1:0] r_out_pc;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [WW-1:0]         r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];

  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_count_next;
  logic                  w_fetch_valid_next;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc_i & ~ADDR_WIDTH'(3);
  assign w_push = fetch_ready_i & r_out & ~r_stale & ~redirect_i;
  assign w_pop  = (r_count != '0) & instr_ready_i & ~redirect_i;

  // Occupancy after this edge; the reservation for next cycle is simply this edge's issue.
  always_comb begin
    w_count_next = r_count;
    if (redirect_i) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_comb begin
    w_fetch_valid_next = !redirect_i && ((w_count_next + CW'(r_fetch_valid)) < CW'(DEPTH));
    w_pc_next = r_pc;
    if (redirect_i) begin
      w_pc_next = w_redirect_pc;
    end else if (r_fetch_valid) begin
      w_pc_next = r_pc + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_pc          <= RESET_PC;
      r_out         <= 1'b0;
      r_stale       <= 1'b0;
      r_out_pc      <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_fetch_valid <= w_fetch_valid_next;
      r_pc          <= w_pc_next;
      r_out         <= r_fetch_valid;
      r_stale       <= r_fetch_valid & redirect_i;
      r_count       <= w_count_next;
      if (r_fetch_valid) begin
        r_out_pc <= r_pc;
      end
      if (redirect_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push && rst_n) begin
      r_mem_data[r_wr_ptr] <= fetch_rdata_i;
      r_mem_pc[r_wr_ptr]   <= r_out_pc;
    end
  end

  assign fetch_valid_o = r_fetch_valid;
  assign fetch_addr_o  = r_pc;
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_mem_data[r_rd_ptr];
  assign instr_pc_o    = r_mem_pc[r_rd_ptr];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetch_cnt <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (w_push)          r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (r_count == '0)   r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch_cnt;
  assign perf_stall_cnt_o = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a one-cycle-latency ROM responder (word = addr ^ 0xA5A5_0000).
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_rdata_i = 32'h0;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic        rom_pend = 1'b0;
  logic [31:0] rom_pend_addr = 32'h0;
  int          rom_reqs = 0;

  fetch_prefetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid_o (fetch_valid_o),
    .fetch_addr_o  (fetch_addr_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_rdata_i (fetch_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk = ~clk;

  // ROM responder: a request seen before an edge is answered at the following edge.
  always @(negedge clk) begin
    fetch_ready_i = rom_pend;
    fetch_rdata_i = rom_pend ? (rom_pend_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    rom_pend      = fetch_valid_o;
    rom_pend_addr = fetch_addr_o;
    if (fetch_valid_o) rom_reqs++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    step(2);
    check_eq("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("rst_fetch_addr", fetch_addr_o, 32'h0);
    check_eq("rst_instr_valid", 32'(instr_valid_o), 32'd0);

    // Fill with decode stalled: exactly four requests, then backpressure.
    rom_reqs = 0;
    rst_n = 1'b1;
    step(1);
    check_eq("fill_first_valid", 32'(fetch_valid_o), 32'd1);
    check_eq("fill_first_addr", fetch_addr_o, 32'h0);
    step(9);
    check_eq("fill_req_count", 32'(rom_reqs), 32'd4);
    check_eq("fill_fetch_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("fill_instr_valid", 32'(instr_valid_o), 32'd1);
    check_eq("fill_head_pc", instr_pc_o, 32'h0);
    check_eq("fill_head_instr", instr_o, 32'hA5A5_0000);
    instr_ready_i = 1'b1;
    step(1);
    check_eq("pop_refetch_valid", 32'(fetch_valid_o), 32'd1);
    check_eq("pop_refetch_addr", fetch_addr_o, 32'h10);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain_pc%0d", i), instr_pc_o, 32'h4 + 32'(4 * i));
      step(1);
    end

    // One-cycle reset while a request is outstanding; the late response must be ignored.
    rst_n = 1'b0;
    step(1);
    check_eq("midrst_fetch_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("midrst_instr_valid", 32'(instr_valid_o), 32'd0);
    check_eq("midrst_fetch_addr", fetch_addr_o, 32'h0);
    rst_n = 1'b1;
    step(1);
    check_eq("late_resp_ignored", 32'(instr_valid_o), 32'd0);
    check_eq("restart_valid", 32'(fetch_valid_o), 32'd1);
    check_eq("restart_addr0", fetch_addr_o, 32'h0);
    step(1);
    check_eq("restart_addr4", fetch_addr_o, 32'h4);
    check_eq("no_bypass", 32'(instr_valid_o), 32'd0);
    step(1);
    check_eq("stream_addr8", fetch_addr_o, 32'h8);
    check_eq("stream_pc0", instr_pc_o, 32'h0);
    check_eq("stream_instr0", instr_o, 32'hA5A5_0000);
    step(1);
    check_eq("stream_pc4", instr_pc_o, 32'h4);
    check_eq("stream_instr4", instr_o, 32'hA5A5_0004);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_eq($sformatf("steady_valid%0d", i), 32'(instr_valid_o), 32'd1);
      check_eq($sformatf("steady_pc%0d", i), instr_pc_o, 32'h8 + 32'(4 * i));
    end

    // Redirect while streaming to an unaligned target.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    step(1);
    redirect_i = 1'b0;
    check_eq("redir_fetch_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("redir_flush", 32'(instr_valid_o), 32'd0);
    step(1);
    check_eq("redir_req_valid", 32'(fetch_valid_o), 32'd1);
    check_eq("redir_req_addr", fetch_addr_o, 32'h100);
    check_eq("redir_stale_drop", 32'(instr_valid_o), 32'd0);
    step(1);
    check_eq("redir_wait", 32'(instr_valid_o), 32'd0);
    step(1);
    check_eq("redir_first_valid", 32'(instr_valid_o), 32'd1);
    check_eq("redir_first_pc", instr_pc_o, 32'h100);
    check_eq("redir_first_instr", instr_o, 32'hA5A5_0100);
    step(1);
    check_eq("redir_second_pc", instr_pc_o, 32'h104);

    // Redirect coinciding with a response and a pop while all slots are committed.
    instr_ready_i = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(5);
    check_eq("full_instr_valid", 32'(instr_valid_o), 32'd1);
    check_eq("full_head_pc", instr_pc_o, 32'h0);
    check_eq("full_fetch_valid", 32'(fetch_valid_o), 32'd0);
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step(1);
    redirect_i = 1'b0;
    check_eq("full_redir_empty", 32'(instr_valid_o), 32'd0);
    check_eq("full_redir_fv", 32'(fetch_valid_o), 32'd0);
    step(1);
    check_eq("full_redir_empty2", 32'(instr_valid_o), 32'd0);
    check_eq("full_redir_addr", fetch_addr_o, 32'h200);
    step(1);
    check_eq("full_redir_empty3", 32'(instr_valid_o), 32'd0);
    step(1);
    check_eq("full_redir_pc0", instr_pc_o, 32'h200);
    step(1);
    check_eq("full_redir_pc1", instr_pc_o, 32'h204);

`ifdef FETCH_PERF_CNT_EN
    // Ten pushes after release, with three empty cycles before the first one lands.
    rst_n = 1'b0;
    step(2);
    check_eq("perf_rst_fetch", perf_fetch_cnt_o, 32'd0);
    rst_n = 1'b1;
    step(12);
    check_eq("perf_fetch_cnt", perf_fetch_cnt_o, 32'd10);
    check_eq("perf_stall_cnt", perf_stall_cnt_o, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
